// File: rtl/rv4028_sram_responder.sv
// RV4028 halfword-bus SRAM target: window decode, programmable read wait states, byte-masked writes.
// Define RV4028_RESP_PREFETCH_EN to prefetch the odd halfword after an even read, making word reads zero-wait on the 2nd half.
module rv4028_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_BITS = 12,
    parameter int          READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [1:0]  wr_n,
    input  logic        rd_n,
    input  logic [1:0]  msk_n,
    input  logic        iorq_n,
    input  logic [1:0]  mreq_n,
    input  logic [15:0] data_in,
    output logic        wait_n,
    output logic [15:0] data_out,
    output logic        data_oe
);
    localparam int         IW    = ADDR_BITS - 1;
    localparam int         DEPTH = 1 << IW;
    localparam logic [3:0] RW    = 4'(READ_WAIT);

    typedef enum logic [1:0] {IDLE, RDATA, WDATA} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [IW-1:0] idx;
    logic [1:0]    msk_q;
    logic [15:0]   mem [DEPTH];

    logic          sel;
    logic          wr_req;
    logic          rd_req;
    logic [IW-1:0] a_idx;
    logic          unused_bits;

`ifdef RV4028_RESP_PREFETCH_EN
    logic [15:0]   pf_q;
    logic [IW-1:0] pf_idx;
    logic          pf_valid;
`endif

    assign sel         = iorq_n & ~mreq_n[1] & (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign wr_req      = sel & (wr_n != 2'b11);
    assign rd_req      = sel & ~rd_n;
    assign a_idx       = addr[ADDR_BITS-1:1];
    assign unused_bits = addr[0] ^ mreq_n[0];

    // A reset landing on the write data phase drops the write; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && state == WDATA) begin
            if (!msk_q[0]) mem[idx][7:0]  <= data_in[7:0];
            if (!msk_q[1]) mem[idx][15:8] <= data_in[15:8];
        end
    end

    // data_out doubles as the read data register; it is zero whenever data_oe is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx      <= '0;
            msk_q    <= 2'b11;
            wait_n   <= 1'b1;
            data_oe  <= 1'b0;
            data_out <= 16'h0000;
`ifdef RV4028_RESP_PREFETCH_EN
            pf_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state <= WDATA;
                        idx   <= a_idx;
                        msk_q <= msk_n;
`ifdef RV4028_RESP_PREFETCH_EN
                        if (a_idx == pf_idx) pf_valid <= 1'b0;
`endif
                    end else if (rd_req) begin
                        state   <= RDATA;
                        idx     <= a_idx;
                        data_oe <= 1'b1;
`ifdef RV4028_RESP_PREFETCH_EN
                        if (pf_valid && a_idx == pf_idx) begin
                            data_out <= pf_q;
                            cnt      <= 4'd0;
                            wait_n   <= 1'b1;
                        end else begin
                            pf_valid <= 1'b0;
                            data_out <= mem[a_idx];
                            cnt      <= RW;
                            wait_n   <= (RW == 4'd0);
                        end
`else
                        data_out <= mem[a_idx];
                        cnt      <= RW;
                        wait_n   <= (RW == 4'd0);
`endif
                    end
                end
                RDATA: begin
                    if (cnt != 4'd0) begin
                        cnt    <= cnt - 4'd1;
                        wait_n <= (cnt == 4'd1);
                    end else begin
                        state    <= IDLE;
                        data_oe  <= 1'b0;
                        data_out <= 16'h0000;
                        wait_n   <= 1'b1;
`ifdef RV4028_RESP_PREFETCH_EN
                        if (!idx[0]) begin
                            pf_q     <= mem[{idx[IW-1:1], 1'b1}];
                            pf_idx   <= {idx[IW-1:1], 1'b1};
                            pf_valid <= 1'b1;
                        end
`endif
                    end
                end
                WDATA:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv4028_sram_responder.sv
// Self-checking bench for rv4028_sram_responder: directed vector table, hand-written corner sequences, random traffic vs model.
`timescale 1ns/1ps
module tb_rv4028_sram_responder;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          RW   = 2;
`ifdef RV4028_RESP_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  wr_n = 2'b11;
    logic        rd_n = 1'b1;
    logic [1:0]  msk_n = 2'b11;
    logic        iorq_n = 1'b1;
    logic [1:0]  mreq_n = 2'b11;
    logic [15:0] data_in = '0;
    logic        wait_n;
    logic [15:0] data_out;
    logic        data_oe;

    always #5 clk = ~clk;

    rv4028_sram_responder #(.BASE_ADDR(BASE), .ADDR_BITS(12), .READ_WAIT(RW)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_n(wr_n), .rd_n(rd_n), .msk_n(msk_n),
        .iorq_n(iorq_n), .mreq_n(mreq_n), .data_in(data_in),
        .wait_n(wait_n), .data_out(data_out), .data_oe(data_oe)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: halfword memory plus the prefetch rules stated as plain bookkeeping.
    logic [15:0] ref_mem [64];
    bit          pf_ok = 1'b0;
    int          pf_index = -1;

    function automatic int model_read(input int i);
        int w;
        w = (PF && pf_ok && i == pf_index) ? 0 : RW;
        if (i != pf_index) pf_ok = 1'b0;
        if (PF && (i % 2) == 0) begin
            pf_ok    = 1'b1;
            pf_index = i + 1;
        end
        return w;
    endfunction

    function automatic void model_write(input int i, input logic [15:0] d, input logic [1:0] m);
        if (!m[0]) ref_mem[i][7:0]  = d[7:0];
        if (!m[1]) ref_mem[i][15:8] = d[15:8];
        if (i == pf_index) pf_ok = 1'b0;
    endfunction

    task automatic bus_idle();
        wr_n = 2'b11; rd_n = 1'b1; mreq_n = 2'b11; iorq_n = 1'b1; msk_n = 2'b11;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] m);
        int k;
        k = $urandom % 3;
        addr = a; msk_n = m; data_in = d; iorq_n = 1'b1;
        wr_n = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
        rd_n = 1'($urandom % 2);
        mreq_n = {1'b0, 1'($urandom % 2)};
        @(negedge clk);
        check("wdata_wait_n", {31'd0, wait_n}, 32'd1);
        check("wdata_oe", {31'd0, data_oe}, 32'd0);
        wr_n = 2'b11; rd_n = 1'b1; mreq_n = 2'b11;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [15:0] d, output int waits,
                            output int oe, output int ncyc, output bit ok);
        addr = a; rd_n = 1'b0; wr_n = 2'b11; iorq_n = 1'b1;
        mreq_n = {1'b0, 1'($urandom % 2)};
        d = '0; waits = 0; oe = 0; ncyc = 0; ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ncyc++;
            if (data_oe) begin
                oe++;
                if (!wait_n) waits++;
                else begin
                    ok = 1'b1;
                    d  = data_out;
                end
            end
        end
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [15:0] exp_d, input int exp_w);
        logic [15:0] d;
        int w, oe, n;
        bit ok;
        bus_read(a, d, w, oe, n, ok);
        check({name, "_done"}, {31'd0, ok}, 32'd1);
        check({name, "_data"}, {16'd0, d}, {16'd0, exp_d});
        check({name, "_waits"}, w, exp_w);
        check({name, "_oe_cycles"}, oe, exp_w + 1);
    endtask

    task automatic ns_access(input string name, input logic [31:0] a, input logic io, input logic mq1,
                             input bit is_wr, input logic [15:0] d);
        int bad;
        bad = 0;
        addr = a; iorq_n = io; mreq_n = {mq1, 1'b0}; msk_n = 2'b00; data_in = d;
        wr_n = is_wr ? 2'b00 : 2'b11;
        rd_n = is_wr ? 1'b1 : 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (data_oe !== 1'b0 || wait_n !== 1'b1 || data_out !== 16'h0) bad++;
        end
        check(name, bad, 0);
        bus_idle();
    endtask

    typedef enum int {OP_WR, OP_RD, OP_NSWR, OP_NSRD} op_e;
    typedef struct {
        op_e         op;
        logic        iorq;
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        logic [15:0] exp_d;
    } vec_t;
    vec_t vt[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d1, d2;
        int w1, w2, oe1, oe2, n1, n2, ew, i, last_rd;
        bit ok1, ok2, after_read;

        vt[0]  = '{OP_WR,   1'b1, BASE | 32'h10, 16'hA55A, 2'b00, 16'h0000};
        vt[1]  = '{OP_RD,   1'b1, BASE | 32'h10, 16'h0000, 2'b00, 16'hA55A};
        vt[2]  = '{OP_WR,   1'b1, BASE | 32'h30, 16'h1234, 2'b00, 16'h0000};
        vt[3]  = '{OP_WR,   1'b1, BASE | 32'h30, 16'hABCD, 2'b10, 16'h0000};
        vt[4]  = '{OP_RD,   1'b1, BASE | 32'h30, 16'h0000, 2'b00, 16'h12CD};
        vt[5]  = '{OP_WR,   1'b1, BASE | 32'h30, 16'hABCD, 2'b01, 16'h0000};
        vt[6]  = '{OP_RD,   1'b1, BASE | 32'h30, 16'h0000, 2'b00, 16'hABCD};
        vt[7]  = '{OP_WR,   1'b1, BASE | 32'h30, 16'h0000, 2'b11, 16'h0000};
        vt[8]  = '{OP_RD,   1'b1, BASE | 32'h30, 16'h0000, 2'b00, 16'hABCD};
        vt[9]  = '{OP_NSWR, 1'b1, 32'h2000_0010, 16'hFFFF, 2'b00, 16'h0000};
        vt[10] = '{OP_NSWR, 1'b0, BASE | 32'h10, 16'hFFFF, 2'b00, 16'h0000};
        vt[11] = '{OP_NSRD, 1'b0, BASE | 32'h10, 16'h0000, 2'b00, 16'h0000};
        vt[12] = '{OP_RD,   1'b1, BASE | 32'h10, 16'h0000, 2'b00, 16'hA55A};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_wait_n", {31'd0, wait_n}, 32'd1);
        check("reset_oe", {31'd0, data_oe}, 32'd0);
        check("reset_data", {16'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 64; k++) begin
            d1 = 16'($urandom);
            bus_write(BASE | 32'(k << 1), d1, 2'b00);
            model_write(k, d1, 2'b00);
        end

        foreach (vt[k]) begin
            i = int'(vt[k].a[11:1]);
            case (vt[k].op)
                OP_WR: begin
                    bus_write(vt[k].a, vt[k].d, vt[k].m);
                    model_write(i, vt[k].d, vt[k].m);
                end
                OP_RD: begin
                    void'(model_read(i));
                    read_chk($sformatf("vec%0d", k), vt[k].a, vt[k].exp_d, RW);
                    bus_idle();
                end
                OP_NSWR: ns_access($sformatf("vec%0d_nosel", k), vt[k].a, vt[k].iorq, 1'b0, 1'b1, vt[k].d);
                default: ns_access($sformatf("vec%0d_nosel", k), vt[k].a, vt[k].iorq, 1'b0, 1'b0, vt[k].d);
            endcase
        end

        // Back-to-back 32-bit read, rd_n held low across the halfword boundary
        bus_write(BASE | 32'h20, 16'h1111, 2'b00); model_write(16, 16'h1111, 2'b00);
        bus_write(BASE | 32'h22, 16'h2222, 2'b00); model_write(17, 16'h2222, 2'b00);
        bus_read(BASE | 32'h20, d1, w1, oe1, n1, ok1);
        bus_read(BASE | 32'h22, d2, w2, oe2, n2, ok2);
        void'(model_read(16));
        void'(model_read(17));
        check("b2b_lo_data", {16'd0, d1}, 32'h1111);
        check("b2b_hi_data", {16'd0, d2}, 32'h2222);
        check("b2b_hi_waits", w2, PF ? 0 : RW);
        check("b2b_total_cycles", n1 + n2 + 1, PF ? (RW + 4) : 2 * (RW + 2));
        bus_idle();

        // Write to the prefetched index must invalidate the prefetch
        void'(model_read(16));
        read_chk("pfinv_lo", BASE | 32'h20, 16'h1111, RW);
        bus_idle();
        bus_write(BASE | 32'h22, 16'h7777, 2'b00); model_write(17, 16'h7777, 2'b00);
        ew = model_read(17);
        read_chk("pfinv_hi", BASE | 32'h22, 16'h7777, ew);
        check("pfinv_hi_full_wait", ew, RW);
        bus_idle();

        // Reset held 3 cycles in the middle of a read
        addr = BASE | 32'h10; rd_n = 1'b0; wr_n = 2'b11; mreq_n = 2'b00; iorq_n = 1'b1;
        @(negedge clk);
        check("midread_oe", {31'd0, data_oe}, 32'd1);
        rst_n = 1'b0;
        wr_n = 2'b11; rd_n = 1'b1; mreq_n = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_wait_n", {31'd0, wait_n}, 32'd1);
            check("rst_mid_oe", {31'd0, data_oe}, 32'd0);
            check("rst_mid_data", {16'd0, data_out}, 32'd0);
        end
        pf_ok = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        void'(model_read(8));
        read_chk("post_reset_rd", BASE | 32'h10, ref_mem[8], RW);
        bus_idle();

        // Reset during a write data phase drops the write
        addr = BASE | 32'h12; wr_n = 2'b00; msk_n = 2'b00; data_in = ~ref_mem[9]; mreq_n = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        wr_n = 2'b11; mreq_n = 2'b11;
        repeat (3) @(negedge clk);
        pf_ok = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        ew = model_read(9);
        read_chk("dropped_write", BASE | 32'h12, ref_mem[9], ew);
        bus_idle();

        // Random traffic against the model
        after_read = 1'b0;
        last_rd = -1;
        for (int t = 0; t < 300; t++) begin
            int op;
            op = $urandom % 8;
            if (op >= 3 && op <= 5) begin
                if (last_rd >= 0 && (last_rd % 2) == 0 && ($urandom % 2) == 1) i = last_rd + 1;
                else i = $urandom_range(0, 63);
                bus_read(BASE | 32'(i << 1), d1, w1, oe1, n1, ok1);
                ew = model_read(i);
                check("rnd_rd_done", {31'd0, ok1}, 32'd1);
                check("rnd_rd_data", {16'd0, d1}, {16'd0, ref_mem[i]});
                check("rnd_rd_waits", w1, ew);
                check("rnd_rd_oe", oe1, ew + 1);
                last_rd = i;
                after_read = 1'b1;
                if ($urandom % 2) begin
                    bus_idle();
                    after_read = 1'b0;
                end
            end else begin
                if (after_read) bus_idle();
                after_read = 1'b0;
                last_rd = -1;
                i = $urandom_range(0, 63);
                d1 = 16'($urandom);
                if (op < 3) begin
                    bus_write(BASE | 32'(i << 1), d1, 2'($urandom));
                    model_write(i, d1, msk_n);
                end else begin
                    case ($urandom % 3)
                        0: ns_access("rnd_nosel_io", BASE | 32'(i << 1), 1'b0, 1'b0, 1'($urandom % 2), d1);
                        1: ns_access("rnd_nosel_mreq", BASE | 32'(i << 1), 1'b1, 1'b1, 1'($urandom % 2), d1);
                        default: ns_access("rnd_nosel_win", (BASE | 32'(i << 1)) ^ (32'd1 << (12 + $urandom % 20)),
                                           1'b1, 1'b0, 1'($urandom % 2), d1);
                    endcase
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
